// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared types and helpers for the add-shift multiplier sequencer.
//   mult_state_t : sequencer states (IDLE, CLEAR, ADD, SHIFT, HOLD)
//   MULT_WIDTH   : default operand width
//   idx_w()      : width of the iteration index for a given operand width
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } mult_state_t;

    localparam int MULT_WIDTH = 8;

    function automatic int idx_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// ---------------------------------------------------------------------------
// mult_bit_counter
// Iteration counter for the multiplier sequencer. Counts 0..WIDTH-1 and
// saturates at WIDTH-1 so it can never wrap.
//   clk   : clock
//   rst   : synchronous active-high reset, count -> 0
//   clr   : synchronous clear, count -> 0
//   en    : advance the count by one (ignored at terminal count)
//   idx   : current count
//   tc    : terminal-count flag, high when idx == WIDTH-1
// ---------------------------------------------------------------------------
import mult_pkg::*;

module mult_bit_counter #(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    output logic [idx_w(WIDTH)-1:0]  idx,
    output logic                     tc
);

    localparam int IW = idx_w(WIDTH);

    logic [IW-1:0] count_d;
    logic [IW-1:0] count_q;

    assign tc  = (count_q == IW'(WIDTH - 1));
    assign idx = count_q;

    // NOTE: count_d gets a value before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + IW'(1);
        end
    end

    // NOTE: registers update with <= so every flop samples the values from
    // before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mult_control.sv
// ---------------------------------------------------------------------------
// mult_control
// Sequencer for the signed add-shift multiplier datapath (X, A, B, adder/
// subtractor, shifter). Converts the Run / ClearA_LoadB levels into per-cycle
// datapath strobes, iterating WIDTH times with a bit counter.
//
// Ports:
//   Clk          : clock, rising edge
//   Reset        : synchronous active-high, forces IDLE and Bit_Idx = 0
//   Run          : level start request (synchronized)
//   ClearA_LoadB : level, clear X/A and load B while idle
//   M            : current LSB of B (multiplier bit under test)
//   M_next       : B bit 1, only with MULT_CTRL_SKIP_ZERO_EN
//   Clr_Ld       : clear X/A, load B (IDLE only)
//   Clr_XA       : clear X/A at start of a computation
//   Add          : A <= A + S
//   Sub          : A <= A - S (sign bit iteration only)
//   Shift        : arithmetic right shift of X:A:B
//   Busy         : high outside IDLE
//   Bit_Idx      : current iteration index
//
// Build option MULT_CTRL_SKIP_ZERO_EN: skip the ADD state for multiplier
// bits that are 0, going straight from one SHIFT (or CLEAR) to the next
// SHIFT. Undefined (default): fixed ADD/SHIFT cadence.
// ---------------------------------------------------------------------------
import mult_pkg::*;

module mult_control #(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Run,
    input  logic                     ClearA_LoadB,
    input  logic                     M,
`ifdef MULT_CTRL_SKIP_ZERO_EN
    input  logic                     M_next,
`endif
    output logic                     Clr_Ld,
    output logic                     Clr_XA,
    output logic                     Add,
    output logic                     Sub,
    output logic                     Shift,
    output logic                     Busy,
    output logic [idx_w(WIDTH)-1:0]  Bit_Idx
);

    mult_state_t state_d;
    mult_state_t state_q;

    logic cnt_clr;
    logic cnt_en;
    logic last_bit;

    mult_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk (Clk),
        .rst (Reset),
        .clr (cnt_clr),
        .en  (cnt_en),
        .idx (Bit_Idx),
        .tc  (last_bit)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        Clr_Ld  = 1'b0;
        Clr_XA  = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Busy    = (state_q != IDLE);
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            IDLE: begin
                // Run has priority: loading B during a start would corrupt
                // the operand the computation is about to use.
                Clr_Ld = ClearA_LoadB & ~Run;
                if (Run) begin
                    state_d = CLEAR;
                end
            end

            CLEAR: begin
                Clr_XA  = 1'b1;
                cnt_clr = 1'b1;
`ifdef MULT_CTRL_SKIP_ZERO_EN
                state_d = M ? ADD : SHIFT;
`else
                state_d = ADD;
`endif
            end

            ADD: begin
                // The top multiplier bit carries negative weight in two's
                // complement, so it subtracts instead of adding.
                if (M) begin
                    Add = ~last_bit;
                    Sub = last_bit;
                end
                state_d = SHIFT;
            end

            SHIFT: begin
                Shift = 1'b1;
                if (last_bit) begin
                    state_d = HOLD;
                end else begin
                    cnt_en = 1'b1;
`ifdef MULT_CTRL_SKIP_ZERO_EN
                    // M_next is the bit M will present after this shift.
                    state_d = M_next ? ADD : SHIFT;
`else
                    state_d = ADD;
`endif
                end
            end

            HOLD: begin
                // Waiting for Run to drop prevents a held Run retriggering.
                if (!Run) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// ---------------------------------------------------------------------------
// tb_mult_control
// Directed testbench for mult_control (WIDTH = 8). Inputs are driven and
// outputs sampled on the falling clock edge; "cycle n" is the period after
// rising edge n, with Run first sampled at edge 0.
// ---------------------------------------------------------------------------
module tb_mult_control;

    localparam int W = 8;

    logic       clk;
    logic       reset;
    logic       run;
    logic       cl;
    logic       m;
`ifdef MULT_CTRL_SKIP_ZERO_EN
    logic       m_next;
`endif
    logic       clr_ld;
    logic       clr_xa;
    logic       add;
    logic       sub;
    logic       shift;
    logic       busy;
    logic [2:0] bit_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int n_add;
    int n_sub;
    int n_shift;

    mult_control #(
        .WIDTH (W)
    ) dut (
        .Clk          (clk),
        .Reset        (reset),
        .Run          (run),
        .ClearA_LoadB (cl),
        .M            (m),
`ifdef MULT_CTRL_SKIP_ZERO_EN
        .M_next       (m_next),
`endif
        .Clr_Ld       (clr_ld),
        .Clr_XA       (clr_xa),
        .Add          (add),
        .Sub          (sub),
        .Shift        (shift),
        .Busy         (busy),
        .Bit_Idx      (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy}
    function automatic logic [5:0] get_vec();
        return {clr_ld, clr_xa, add, sub, shift, busy};
    endfunction

    // Expected strobes in cycle c of a default-build run with M held constant.
    function automatic logic [5:0] exp_seq(input int c, input logic mv);
        int k;
        if (c == 1)         return 6'b010001;
        if (c >= 2 * W + 2) return 6'b000001;
        if (c % 2 == 0) begin
            k = (c - 2) / 2;
            return {2'b00, mv && (k < W - 1), mv && (k == W - 1), 2'b01};
        end
        return 6'b000011;
    endfunction

    function automatic int exp_idx(input int c);
        if (c >= 2 * W + 2) return W - 1;
        if (c % 2 == 0)     return (c - 2) / 2;
        return (c - 3) / 2;
    endfunction

    task automatic clear_counts();
        n_add   = 0;
        n_sub   = 0;
        n_shift = 0;
    endtask

    task automatic tally();
        if (add)   n_add++;
        if (sub)   n_sub++;
        if (shift) n_shift++;
    endtask

    task automatic set_m(input logic v);
        m = v;
`ifdef MULT_CTRL_SKIP_ZERO_EN
        m_next = v;
`endif
    endtask

`ifdef MULT_CTRL_SKIP_ZERO_EN
    logic [7:0] b_model;
    logic [5:0] skip_exp [12];
`endif

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        cl    = 1'b0;
        set_m(1'b0);

        // ---- reset, then idle with ClearA_LoadB ----
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cl    = 1'b1;
        @(negedge clk);
        check("rst_vec_cl1", get_vec(), 6'b100000);
        check("rst_idx", bit_idx, 0);
        cl = 1'b0;
        #1;
        check("rst_vec_cl0", get_vec(), 6'b000000);

        // ---- M tied 1, Run held 25 cycles ----
        @(negedge clk);
        set_m(1'b1);
        run = 1'b1;
        clear_counts();
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            check($sformatf("m1_vec_c%0d", c), get_vec(), exp_seq(c, 1'b1));
            if (c >= 2) check($sformatf("m1_idx_c%0d", c), bit_idx, exp_idx(c));
            tally();
        end
        check("m1_adds", n_add, 7);
        check("m1_subs", n_sub, 1);
        check("m1_shifts", n_shift, 8);
        run = 1'b0;
        @(negedge clk);
        check("m1_idle", get_vec(), 6'b000000);

        // ---- M tied 0, one-cycle Run pulse ----
`ifndef MULT_CTRL_SKIP_ZERO_EN
        set_m(1'b0);
        run = 1'b1;
        clear_counts();
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            check($sformatf("m0_vec_c%0d", c), get_vec(), exp_seq(c, 1'b0));
            tally();
            run = 1'b0;
        end
        check("m0_addsub", n_add + n_sub, 0);
        check("m0_shifts", n_shift, 8);
        @(negedge clk);
        check("m0_idle_c19", get_vec(), 6'b000000);
`endif

        // ---- Run and ClearA_LoadB together, ClearA_LoadB toggled in HOLD ----
        set_m(1'b1);
        cl = 1'b1;
        @(negedge clk);
        check("both_pre", get_vec(), 6'b100000);
        run = 1'b1;
        #1;
        check("both_clr_ld", clr_ld, 1'b0);
        @(negedge clk);
        check("both_clear_c1", get_vec(), exp_seq(1, 1'b1));
        for (int c = 2; c <= 22; c++) begin
            cl = ~cl;
            @(negedge clk);
            check($sformatf("both_vec_c%0d", c), get_vec(), exp_seq(c, 1'b1));
        end
        run = 1'b0;
        cl  = 1'b0;
        @(negedge clk);
        check("both_idle", get_vec(), 6'b000000);

        // ---- Reset during cycle 9, then a fresh run ----
        run = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("abort_vec_c%0d", c), get_vec(), exp_seq(c, 1'b1));
        end
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        check("abort_c10_vec", get_vec(), 6'b000000);
        check("abort_c10_idx", bit_idx, 0);
        reset = 1'b0;
        clear_counts();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tally();
        end
        check("abort_quiet", n_add + n_sub + n_shift, 0);
        run = 1'b1;
        clear_counts();
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            check($sformatf("rerun_vec_c%0d", c), get_vec(), exp_seq(c, 1'b1));
            tally();
            run = 1'b0;
        end
        check("rerun_shifts", n_shift, 8);
        check("rerun_adds", n_add, 7);
        @(negedge clk);
        check("rerun_idle", get_vec(), 6'b000000);

`ifdef MULT_CTRL_SKIP_ZERO_EN
        // ---- zero-skip with B = 0000_0101 ----
        skip_exp = '{6'b010001, 6'b001001, 6'b000011, 6'b000011,
                     6'b001001, 6'b000011, 6'b000011, 6'b000011,
                     6'b000011, 6'b000011, 6'b000011, 6'b000001};
        b_model = 8'b0000_0101;
        m       = b_model[0];
        m_next  = b_model[1];
        run     = 1'b1;
        clear_counts();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("skip_vec_c%0d", c), get_vec(), skip_exp[c-1]);
            tally();
            run = 1'b0;
            if (shift) b_model = b_model >> 1;
            m      = b_model[0];
            m_next = b_model[1];
        end
        check("skip_adds", n_add, 2);
        check("skip_subs", n_sub, 0);
        check("skip_shifts", n_shift, 8);
        @(negedge clk);
        check("skip_idle", get_vec(), 6'b000000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
- Sequencer for the 8-bit signed add-shift multiplier datapath: registers X, A, B, adder/subtractor and shifter.
- Turns the board-level Run and ClearA_LoadB controls into per-cycle Clr_Ld, Clr_XA, Add, Sub and Shift strobes.
- Uses a bit counter instead of one unrolled state per bit, so operand width is a parameter.
- Sits between the switch/button synchronizers and the multiplier datapath.

Parameters:
- WIDTH, 8, operand width in bits; equals the number of add/shift iterations; legal range 2..32.

Ports:
- Clk  input  1  system clock, all state changes on its rising edge
- Reset  input  1  synchronous, active-high; forces IDLE
- Run  input  1  level start request (already synchronized)
- ClearA_LoadB  input  1  level: clear X/A and load B from switches while idle
- M  input  1  current LSB of register B (multiplier bit under test)
- Clr_Ld  output  1  clear X and A, load B; only in IDLE
- Clr_XA  output  1  clear X and A at start of a computation
- Add  output  1  A <= A + S (sign-extended), X updated
- Sub  output  1  A <= A - S, X updated (final iteration only)
- Shift  output  1  arithmetic right shift of X:A:B by one
- Busy  output  1  high in every state except IDLE
- Bit_Idx  output  $clog2(WIDTH)  current iteration index, 0..WIDTH-1

Behaviour:
- Clock and reset: one clock, Clk; Reset is synchronous and active-high.
- State encoding: enum IDLE, CLEAR, ADD, SHIFT, HOLD.
- Registered state: state and Bit_Idx only.
- Outputs: all combinational from state, Bit_Idx, M and the inputs.
- Reset: next edge gives state=IDLE, Bit_Idx=0. Clr_XA, Add, Sub, Shift and Busy are 0. Clr_Ld = ClearA_LoadB & ~Run.
- IDLE:
  - Clr_Ld = ClearA_LoadB & ~Run.
  - Run=1 goes to CLEAR. Run wins when both inputs are high.
- CLEAR:
  - Clr_XA=1 for exactly one cycle; Bit_Idx <= 0; go to ADD.
- ADD:
  - If M=1 and Bit_Idx < WIDTH-1: Add=1.
  - If M=1 and Bit_Idx == WIDTH-1: Sub=1 (two's-complement sign bit).
  - If M=0: neither strobe.
  - Always go to SHIFT.
- SHIFT:
  - Shift=1.
  - If Bit_Idx == WIDTH-1: go to HOLD, Bit_Idx holds.
  - Otherwise Bit_Idx increments and state returns to ADD.
- HOLD:
  - No strobes; Busy=1; ClearA_LoadB is ignored.
  - Run=0 goes to IDLE.
- Latency, default build: Run sampled at edge 0 gives CLEAR in cycle 1, ADDk in cycle 2+2k, SHIFTk in cycle 3+2k, HOLD in cycle 2*WIDTH+2.
- Add and Sub are mutually exclusive. Shift is never asserted in the same cycle as Add or Sub. Exactly WIDTH Shift pulses per run.
- Run deasserted mid-computation is ignored; the sequence completes.
- A held Run does not retrigger. A new run requires at least one IDLE cycle with Run=0 observed.
- Reset mid-operation aborts the run at the next edge with no further strobes. Datapath contents are left as-is.
- M is sampled only in ADD; M changes in other states have no effect.
- Bit_Idx never exceeds WIDTH-1, so it cannot wrap.

Optional Feature:
- Macro: MULT_CTRL_SKIP_ZERO_EN.
- Defined:
  - In SHIFT of iteration k < WIDTH-1, if the next multiplier bit is 0, the state machine goes straight to the next SHIFT and skips the ADD.
  - The next multiplier bit is the value M will show after the shift, i.e. B bit 1, supplied on an extra input port M_next.
  - CLEAR also skips ADD0 when M=0.
  - Latency becomes 2 + WIDTH + popcount(B) cycles to HOLD.
  - Shift count, strobe exclusivity and the final Sub rule are unchanged.
- Undefined: M_next is absent and timing is fixed as above.

Decomposition:
- Package mult_pkg:
  - state enum mult_state_t;
  - localparam MULT_WIDTH = 8;
  - function idx_w(WIDTH) returning $clog2(WIDTH).
- Sub-module mult_bit_counter:
  - sync clear, enable, terminal-count flag at WIDTH-1;
  - instantiated once for Bit_Idx.
- Everything else stays in one two-process FSM in mult_control.

Test Plan:
- Reset=1 for 2 cycles, then ClearA_LoadB=1, Run=0 -> state IDLE, Clr_Ld=1, all other strobes 0, Busy=0.
- WIDTH=8, M tied 1, Run held high 25 cycles:
  - Clr_XA in cycle 1;
  - Add in cycles 2,4,...,14 (7 pulses);
  - Sub in cycle 16;
  - Shift in cycles 3,5,...,17 (8 pulses);
  - Busy stays 1 in HOLD until Run falls;
  - no second run.
- M tied 0, single Run pulse of 1 cycle -> 8 Shift pulses, zero Add/Sub, HOLD reached in cycle 18, IDLE the cycle after, because Run=0.
- Run=1 and ClearA_LoadB=1 together in IDLE -> Clr_Ld=0, CLEAR next cycle. Toggle ClearA_LoadB during HOLD -> Clr_Ld stays 0.
- Reset asserted in cycle 9 of a run -> IDLE in cycle 10, Bit_Idx=0, no Add/Sub/Shift afterwards. A new Run completes the normal 8-shift sequence.
- With MULT_CTRL_SKIP_ZERO_EN and B=8'b0000_0101 (M/M_next driven from a B model) -> Add twice (bits 0 and 2), Sub never, 8 Shifts, HOLD in cycle 12.
